// File: rtl/pattern_pkg.sv
// Shared definitions for the serial test-pattern generator/checker pair.
package pattern_pkg;

  // Default pattern word, transmitted LSB first.
  localparam logic [31:0] PatternDefault = 32'hAA550FF0;

  // Checker lock state.
  typedef enum logic {
    StSearch = 1'b0,
    StLocked = 1'b1
  } state_e;

  // Width of the consecutive-bad-word counter.
  localparam int unsigned BadWordsW = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Next count: clear first, otherwise increment until all ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pattern_checker.sv
// Receive-side checker: finds the pattern word boundary in the serial stream,
// then compares every later bit and counts errored bits and completed words.
module pattern_checker
  import pattern_pkg::*;
#(
  parameter logic [31:0] PATTERN    = PatternDefault,
  parameter int unsigned LOSS_WORDS = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [BadWordsW-1:0] LossCnt = BadWordsW'(LOSS_WORDS);

  // Only the 31 newest bits are kept; with the incoming bit they form the
  // 32-bit search window. The oldest bit would be shifted out unused.
  logic [30:0]          sreg_q, sreg_d;
  logic [4:0]           idx_q, idx_d;
  logic                 werr_q, werr_d;
  logic [BadWordsW-1:0] bad_q, bad_d;
  logic                 pulse_q, pulse_d;
  state_e               state_q, state_d;

  logic [31:0]          window;
  logic [BadWordsW-1:0] bad_inc;
  logic                 mismatch;
  logic                 err_inc;
  logic                 word_inc;

  assign window   = {bit_in, sreg_q};
  assign bad_inc  = bad_q + 1'b1;
  assign mismatch = bit_in != PATTERN[idx_q];

  // Next-state: search for the pattern, then track per-word errors while locked.
  always_comb begin
    sreg_d   = sreg_q;
    idx_d    = idx_q;
    werr_d   = werr_q;
    bad_d    = bad_q;
    state_d  = state_q;
    pulse_d  = 1'b0;
    err_inc  = 1'b0;
    word_inc = 1'b0;
    if (bit_valid) begin
      sreg_d = window[31:1];
      unique case (state_q)
        StSearch: begin
          if (window == PATTERN) begin
            state_d = StLocked;
            idx_d   = '0;
            werr_d  = 1'b0;
            bad_d   = '0;
          end
        end
        StLocked: begin
          idx_d = idx_q + 5'd1;
          if (mismatch) begin
            pulse_d = 1'b1;
            err_inc = 1'b1;
            werr_d  = 1'b1;
          end
          if (idx_q == 5'd31) begin
            word_inc = 1'b1;
            werr_d   = 1'b0;
            if (werr_q || mismatch) begin
              bad_d = bad_inc;
              if (bad_inc == LossCnt) begin
                state_d = StSearch;
              end
            end else begin
              bad_d = '0;
            end
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sreg_q  <= '0;
      idx_q   <= '0;
      werr_q  <= 1'b0;
      bad_q   <= '0;
      pulse_q <= 1'b0;
      state_q <= StSearch;
    end else begin
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      werr_q  <= werr_d;
      bad_q   <= bad_d;
      pulse_q <= pulse_d;
      state_q <= state_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk     (clk),
    .aresetn (aresetn),
    .inc     (err_inc),
    .clr     (clear),
    .count   (err_count)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_word_cnt (
    .clk     (clk),
    .aresetn (aresetn),
    .inc     (word_inc),
    .clr     (clear),
    .count   (word_count)
  );

  assign locked    = (state_q == StLocked);
  assign err_pulse = pulse_q;

endmodule
